// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - bitwise logic unit with a registered result FIFO
// Optional stat_ones counter under LOGIC_GATE_PIPE_STATS_EN.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_all,
    output logic             out_valid,
    input  logic             out_ready
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    output logic [15:0]      stat_ones
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    head_next;
    logic [AW:0]      count;
    logic [AW:0]      remaining;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] out_next;
    logic             accept;
    logic             pop;

    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = a ^ b;
            3'b011:  result = ~(a & b);
            3'b100:  result = ~(a | b);
            3'b101:  result = ~(a ^ b);
            3'b110:  result = a;
            default: result = ~a;
        endcase
    end

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign remaining = count - {{AW{1'b0}}, pop};

    // The output register is loaded with whatever will sit at the head after this edge,
    // bypassing the array when the head is the entry being written right now.
    always_comb begin
        head_next = pop ? rd_ptr + AW'(1) : rd_ptr;
        out_next  = out;
        if (remaining == '0) begin
            if (accept) begin
                out_next = result;
            end
        end else begin
            out_next = mem[head_next];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && rst_n) begin
            mem[wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out     <= '0;
            out_all <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= head_next;
            count   <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
            out     <= out_next;
            out_all <= &out_next;
        end
    end

`ifdef LOGIC_GATE_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ones <= '0;
        end else if (pop && out_all && stat_ones != 16'hFFFF) begin
            stat_ones <= stat_ones + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - self-checking bench for logic_gate_pipe
// Optional stat_ones checks under LOGIC_GATE_PIPE_STATS_EN.
module tb_logic_gate_pipe;

    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_all;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic [15:0]  stat_ones;
`endif

    logic [W-1:0] q [$];
    logic [W-1:0] last_out;
    int           m_stats;
    int           n_checks = 0;
    int           n_fails = 0;

    logic_gate_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_all(out_all), .out_valid(out_valid), .out_ready(out_ready)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        , .stat_ones(stat_ones)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] o);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            int p = x[i] + y[i];
            case (o)
                3'd0: r[i] = (p == 2);
                3'd1: r[i] = (p >= 1);
                3'd2: r[i] = (p == 1);
                3'd3: r[i] = (p != 2);
                3'd4: r[i] = (p == 0);
                3'd5: r[i] = (p != 1);
                3'd6: r[i] = x[i];
                default: r[i] = !x[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic iv, input logic ordy,
                        input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] iop);
        logic acc;
        logic pp;
        rst_n = rv; in_valid = iv; out_ready = ordy; a = ia; b = ib; op = iop;
        acc = iv && (q.size() < D);
        pp  = ordy && (q.size() > 0);
        @(posedge clk);
        if (!rv) begin
            q.delete();
            last_out = '0;
            m_stats = 0;
        end else begin
            if (pp) begin
                if (q[0] == {W{1'b1}} && m_stats < 65535) m_stats++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(ref_op(ia, ib, iop));
            if (q.size() > 0) last_out = q[0];
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < D));
        check("out", 64'(out), 64'(last_out));
        check("out_all", 64'(out_all), 64'(last_out == {W{1'b1}}));
`ifdef LOGIC_GATE_PIPE_STATS_EN
        check("stat_ones", 64'(stat_ones), 64'(m_stats));
`endif
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30};
        vecs[1] = '{8'hAA, 8'h0F, 3'd0, 8'h0A};
        vecs[2] = '{8'hAA, 8'h0F, 3'd1, 8'hAF};
        vecs[3] = '{8'hAA, 8'h0F, 3'd2, 8'hA5};
        vecs[4] = '{8'hAA, 8'h0F, 3'd3, 8'hF5};
        vecs[5] = '{8'hAA, 8'h0F, 3'd4, 8'h50};
        vecs[6] = '{8'hAA, 8'h0F, 3'd5, 8'h5A};
        vecs[7] = '{8'hAA, 8'h0F, 3'd6, 8'hAA};
        vecs[8] = '{8'hAA, 8'h0F, 3'd7, 8'h55};
        last_out = '0;
        m_stats = 0;

        step(0, 0, 0, 0, 0, 0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out", 64'(out), 64'd0);

        // Op table with out_ready held high: each result appears one edge after accept
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 1, vecs[i].a, vecs[i].b, vecs[i].op);
            check("vec_out", 64'(out), 64'(vecs[i].exp));
            check("vec_valid", 64'(out_valid), 64'd1);
        end
        step(1, 0, 1, 0, 0, 0);
        check("drain_hold", 64'(out), 64'h55);

        // Backpressure: third accept is refused while full
        step(1, 1, 0, 8'h11, 8'h00, 3'd6);
        step(1, 1, 0, 8'h22, 8'h00, 3'd6);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step(1, 1, 0, 8'h33, 8'h00, 3'd6);
        check("third_refused_head", 64'(out), 64'h11);
        // Full with both valid and ready: only the pop happens
        step(1, 1, 1, 8'h44, 8'h00, 3'd6);
        check("full_both_out", 64'(out), 64'h22);
        check("full_both_in_ready", 64'(in_ready), 64'd1);
        step(1, 1, 1, 8'h55, 8'h00, 3'd6);
        check("occ1_both_out", 64'(out), 64'h55);
        step(1, 0, 1, 0, 0, 0);
        check("occ1_drained", 64'(out_valid), 64'd0);

        // Reset with two entries buffered discards them
        step(1, 1, 0, 8'hA1, 8'h00, 3'd6);
        step(1, 1, 0, 8'hA2, 8'h00, 3'd6);
        step(0, 1, 1, 8'hA3, 8'h00, 3'd6);
        check("midreset_out", 64'(out), 64'd0);
        check("midreset_valid", 64'(out_valid), 64'd0);
        step(1, 1, 1, 8'h5C, 8'h00, 3'd6);
        check("post_reset_first", 64'(out), 64'h5C);
        step(1, 0, 1, 0, 0, 0);

`ifdef LOGIC_GATE_PIPE_STATS_EN
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8'hFF, 8'hFF, 3'd0);
        step(1, 0, 1, 0, 0, 0);
        check("stats_three", 64'(stat_ones), 64'd3);
        step(0, 0, 0, 0, 0, 0);
        check("stats_reset", 64'(stat_ones), 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom),
                 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the result-buffer depth in entries (power of two, legal 2..16).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset (one clock; synchronous, active-low).
REQ-005 The block SHALL have port a  input  WIDTH  first operand.
REQ-006 The block SHALL have port b  input  WIDTH  second operand.
REQ-007 The block SHALL have port op  input  3  operation select.
REQ-008 The block SHALL have port in_valid  input  1  operands and op valid this cycle.
REQ-009 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-010 The block SHALL have port out  output  WIDTH  result at buffer head.
REQ-011 The block SHALL have port out_all  output  1  AND-reduction of out.
REQ-012 The block SHALL have port out_valid  output  1  out and out_all are valid.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes the head result.

Function
REQ-014 The op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass a, 111 NOT a; b is ignored for 110 and 111.
REQ-015 The result SHALL be computed bitwise over all WIDTH bits; out_all SHALL equal the AND-reduction of the stored result.
REQ-016 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; the result SHALL then be written at the buffer tail.
REQ-017 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1; the buffer head SHALL then advance.
REQ-018 Results SHALL leave in accept order (FIFO); none SHALL be dropped or duplicated.
REQ-019 Latency SHALL be 1 cycle: a result accepted at edge N SHALL be on out with out_valid=1 after edge N if the buffer was empty.
REQ-020 in_ready SHALL be 1 exactly when occupancy < DEPTH; it SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be 1 exactly when occupancy > 0.
REQ-022 When accept and pop fall on the same edge, occupancy SHALL be unchanged and both SHALL take effect.
REQ-023 When full, in_valid SHALL be ignored even if out_ready=1 on that edge.
REQ-024 When empty, out_ready SHALL be ignored; out SHALL hold its last value (all zeros after reset).
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be a log2(DEPTH)+1-bit counter.
REQ-026 out, out_valid and out_all SHALL be driven from registers only, with no combinational path from a, b or op.

Reset
REQ-027 When rst_n=0 at a rising edge, occupancy and both pointers SHALL clear and out SHALL be all zeros.
REQ-028 After that edge, out_valid=0, out_all=0 and in_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered results; no accept or pop SHALL occur on a reset edge.
REQ-030 Reset SHALL NOT act between clock edges.

Configuration
REQ-031 With macro LOGIC_GATE_PIPE_STATS_EN defined, the block SHALL add output stat_ones (16 bits), a counter of popped results with out_all=1.
REQ-032 stat_ones SHALL saturate at 16'hFFFF and SHALL clear on reset.
REQ-033 With LOGIC_GATE_PIPE_STATS_EN undefined, stat_ones and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 WIDTH=8; a=8'hF0, b=8'h3C, op=000 accepted with out_ready=1 -> next cycle out=8'h30, out_valid=1, out_all=0.
REQ-035 Sweep op 000..111 with a=8'hAA, b=8'h0F -> out = 0A, AF, A5, F5, 50, 5A, AA, 55 in order.
REQ-036 out_ready=0, three accepts at DEPTH=2 -> in_ready=0 after the second; the third is not taken; out_ready=1 then pops the first two in order.
REQ-037 Buffer full with in_valid=1 and out_ready=1 on the same edge -> only a pop; occupancy becomes 1. At occupancy 1 with both -> occupancy stays 1.
REQ-038 rst_n=0 for one edge with 2 entries buffered -> out_valid=0, in_ready=1, out=8'h00; the discarded results never appear.
REQ-039 With STATS_EN: pop a=8'hFF, b=8'hFF, op=000 three times -> stat_ones=3; reset -> stat_ones=0.
